// File: rtl/level_sequencer_pkg.sv
// Shared types and widths for the level sequencer: FSM states, counter widths
// and a saturating score adder.
package level_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    DEATH,
    CLEAR,
    GAME_OVER,
    WIN
  } state_e;

  localparam int NUM_HOMES = 5;
  localparam int LEVEL_W   = 8;
  localparam int TIME_W    = 11;
  localparam int SCORE_W   = 16;
  localparam int LIVES_W   = 3;
  localparam int PAUSE_W   = 8;

  localparam logic [NUM_HOMES-1:0] ALL_HOMES = '1;

  // Score never wraps: an overflowing add pins the result at all-ones.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Event inputs from the frog/collision logic and status outputs to the lane
// movers and HUD, bundled as one port.
interface level_sequencer_if;
  import level_pkg::*;

  logic                 frame_tick;
  logic                 Start;
  logic                 FrogDied;
  logic                 FrogHome;
  logic [2:0]           HomeSlot;
  logic [LEVEL_W-1:0]   Level;
  logic                 LevelLoad;
  logic                 FrogRespawn;
  logic                 Running;
  logic [LIVES_W-1:0]   Lives;
  logic [NUM_HOMES-1:0] HomesFilled;
  logic [TIME_W-1:0]    TimeLeft;
  logic [SCORE_W-1:0]   Score;
  logic                 GameOver;
  logic                 GameWon;

  modport master (
    output frame_tick, Start, FrogDied, FrogHome, HomeSlot,
    input  Level, LevelLoad, FrogRespawn, Running, Lives, HomesFilled,
           TimeLeft, Score, GameOver, GameWon
  );

  modport slave (
    input  frame_tick, Start, FrogDied, FrogHome, HomeSlot,
    output Level, LevelLoad, FrogRespawn, Running, Lives, HomesFilled,
           TimeLeft, Score, GameOver, GameWon
  );
endinterface

// File: rtl/level_sequencer_frame_timer.sv
// Loadable down-counter stepped by frame ticks; expire_o flags the tick that
// takes the count from 1 to 0.
module frame_timer #(
  parameter int unsigned      W         = 11,
  parameter logic [W-1:0]     RESET_VAL = '0
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic [W-1:0] count_o,
  output logic         expire_o
);

  logic [W-1:0] count_q, count_d;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: reset is sampled on the clock edge (synchronous), and state is
  // updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = tick_i && (count_q == W'(1));

endmodule

// File: rtl/level_sequencer.sv
// Game-progress FSM: sequences title, load, play, pauses and end states, and
// keeps lives, filled homes, round timer and score.
module level_sequencer
  import level_pkg::*;
#(
  parameter int START_LIVES  = 3,
  parameter int MAX_LEVEL    = 3,
  parameter int ROUND_FRAMES = 1800,
  parameter int PAUSE_FRAMES = 60,
  parameter int HOME_PTS     = 50,
  parameter int LEVEL_PTS    = 1000
) (
  input  logic               Clk,
  input  logic               Reset_n,
  level_sequencer_if.slave   bus
);

  state_e               state_q, state_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [NUM_HOMES-1:0] homes_q, homes_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 respawn_q, respawn_d;

  logic                 time_load, time_tick, time_out;
  logic                 pause_load, pause_tick, pause_done;
  logic [TIME_W-1:0]    time_left;
  logic [PAUSE_W-1:0]   pause_left_unused;
  logic [NUM_HOMES-1:0] slot_mask;
  logic                 slot_ok;

  frame_timer #(.W(TIME_W), .RESET_VAL(TIME_W'(ROUND_FRAMES))) u_round (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .load_i     (time_load),
    .load_val_i (TIME_W'(ROUND_FRAMES)),
    .tick_i     (time_tick),
    .count_o    (time_left),
    .expire_o   (time_out)
  );

  frame_timer #(.W(PAUSE_W), .RESET_VAL(PAUSE_W'(PAUSE_FRAMES))) u_pause (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .load_i     (pause_load),
    .load_val_i (PAUSE_W'(PAUSE_FRAMES)),
    .tick_i     (pause_tick),
    .count_o    (pause_left_unused),
    .expire_o   (pause_done)
  );

  // Out-of-range slots produce an empty mask and so never count as valid.
  assign slot_mask = (bus.HomeSlot < 3'(NUM_HOMES)) ? (NUM_HOMES'(1) << bus.HomeSlot) : '0;
  assign slot_ok   = (slot_mask != '0) && ((homes_q & slot_mask) == '0);

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    lives_d    = lives_q;
    homes_d    = homes_q;
    score_d    = score_q;
    respawn_d  = 1'b0;
    time_load  = 1'b0;
    time_tick  = 1'b0;
    pause_load = 1'b0;
    pause_tick = 1'b0;

    unique case (state_q)
      IDLE: if (bus.Start) state_d = LOAD;
      LOAD: state_d = PLAY;
      PLAY: begin
        time_tick = bus.frame_tick;
        if (bus.FrogDied || (bus.FrogHome && !slot_ok) || time_out) begin
          lives_d    = (lives_q != '0) ? lives_q - 1'b1 : '0;
          pause_load = 1'b1;
          state_d    = DEATH;
        end else if (bus.FrogHome) begin
          homes_d = homes_q | slot_mask;
          score_d = sat_add(score_q, SCORE_W'(HOME_PTS));
          if (homes_d == ALL_HOMES) begin
            score_d    = sat_add(score_d, SCORE_W'(LEVEL_PTS));
            pause_load = 1'b1;
            state_d    = CLEAR;
          end else begin
            respawn_d = 1'b1;
            time_load = 1'b1;
          end
        end
      end
      DEATH: begin
        pause_tick = bus.frame_tick;
        if (pause_done) begin
          if (lives_q == '0) begin
            state_d = GAME_OVER;
          end else begin
            respawn_d = 1'b1;
            time_load = 1'b1;
            state_d   = PLAY;
          end
        end
      end
      CLEAR: begin
        pause_tick = bus.frame_tick;
        if (pause_done) begin
          if (level_q >= LEVEL_W'(MAX_LEVEL)) begin
            state_d = WIN;
          end else begin
            level_d = level_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      GAME_OVER, WIN: begin
        if (bus.Start) begin
          level_d = LEVEL_W'(1);
          lives_d = LIVES_W'(START_LIVES);
          score_d = '0;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Entering LOAD prepares the new attempt so LOAD-cycle outputs are fresh.
    if (state_d == LOAD) begin
      respawn_d = 1'b1;
      time_load = 1'b1;
      homes_d   = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      level_q   <= LEVEL_W'(1);
      lives_q   <= LIVES_W'(START_LIVES);
      homes_q   <= '0;
      score_q   <= '0;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      lives_q   <= lives_d;
      homes_q   <= homes_d;
      score_q   <= score_d;
      respawn_q <= respawn_d;
    end
  end

  assign bus.Level       = level_q;
  assign bus.LevelLoad   = (state_q == LOAD);
  assign bus.FrogRespawn = respawn_q;
  assign bus.Running     = (state_q == PLAY);
  assign bus.Lives       = lives_q;
  assign bus.HomesFilled = homes_q;
  assign bus.TimeLeft    = time_left;
  assign bus.Score       = score_q;
  assign bus.GameOver    = (state_q == GAME_OVER);
  assign bus.GameWon     = (state_q == WIN);

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: one default-parameter DUT for the game
// flow and a short-round DUT for the timer-expiry and mid-pause reset cases.
module tb_level_sequencer;
  import level_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n;
  int   vectors     = 0;
  int   miscompares = 0;

  level_sequencer_if bus ();
  level_sequencer_if bus_t ();

  level_sequencer dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  level_sequencer #(.ROUND_FRAMES(4), .PAUSE_FRAMES(2)) dut_t (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus_t)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      cyc();
    end
    bus.frame_tick = 1'b0;
  endtask

  task automatic home(input logic [2:0] slot);
    bus.FrogHome = 1'b1;
    bus.HomeSlot = slot;
    cyc();
    bus.FrogHome = 1'b0;
  endtask

  initial begin
    bus.frame_tick   = 1'b0;  bus.Start   = 1'b1;  bus.FrogDied   = 1'b0;
    bus.FrogHome     = 1'b0;  bus.HomeSlot = 3'd0;
    bus_t.frame_tick = 1'b0;  bus_t.Start = 1'b0;  bus_t.FrogDied = 1'b0;
    bus_t.FrogHome   = 1'b0;  bus_t.HomeSlot = 3'd0;
    Reset_n = 1'b0;
    cyc();
    cyc();

    // Reset values with Start held
    check("rst_level",   bus.Level, 1);
    check("rst_lives",   bus.Lives, 3);
    check("rst_homes",   bus.HomesFilled, 0);
    check("rst_time",    bus.TimeLeft, 1800);
    check("rst_score",   bus.Score, 0);
    check("rst_running", bus.Running, 0);
    check("rst_load",    bus.LevelLoad, 0);
    check("rst_respawn", bus.FrogRespawn, 0);
    check("rst_over",    bus.GameOver, 0);
    check("rst_won",     bus.GameWon, 0);

    Reset_n = 1'b1;
    cyc();
    check("load_pulse",   bus.LevelLoad, 1);
    check("load_respawn", bus.FrogRespawn, 1);
    bus.Start = 1'b0;
    cyc();
    check("play_running", bus.Running, 1);
    check("play_load",    bus.LevelLoad, 0);
    check("play_level",   bus.Level, 1);
    check("play_lives",   bus.Lives, 3);
    check("play_time",    bus.TimeLeft, 1800);

    // Fill every home on level 1
    for (int s = 0; s < 4; s++) begin
      home(3'(s));
      check("home_respawn", bus.FrogRespawn, 1);
      cyc();
    end
    home(3'd4);
    check("clr_score",   bus.Score, 1250);
    check("clr_homes",   bus.HomesFilled, 5'h1F);
    check("clr_running", bus.Running, 0);
    check("clr_respawn", bus.FrogRespawn, 0);
    cyc();
    frames(59);
    check("clr_wait_level", bus.Level, 1);
    check("clr_wait_load",  bus.LevelLoad, 0);
    frames(1);
    check("lvl2_level",   bus.Level, 2);
    check("lvl2_load",    bus.LevelLoad, 1);
    check("lvl2_homes",   bus.HomesFilled, 0);
    check("lvl2_respawn", bus.FrogRespawn, 1);
    cyc();
    check("lvl2_running", bus.Running, 1);
    check("lvl2_time",    bus.TimeLeft, 1800);

    // Ticks, valid home, then a repeat of the same slot
    frames(3);
    check("tick_time", bus.TimeLeft, 1797);
    home(3'd2);
    check("h2_homes",   bus.HomesFilled, 5'b00100);
    check("h2_score",   bus.Score, 1300);
    check("h2_time",    bus.TimeLeft, 1800);
    check("h2_respawn", bus.FrogRespawn, 1);
    cyc();
    frames(2);
    home(3'd2);
    check("dup_lives",   bus.Lives, 2);
    check("dup_running", bus.Running, 0);
    check("dup_homes",   bus.HomesFilled, 5'b00100);
    check("dup_score",   bus.Score, 1300);
    check("dup_time",    bus.TimeLeft, 1798);

    // Start and events are ignored during the pause
    bus.Start = 1'b1;  bus.FrogHome = 1'b1;  bus.HomeSlot = 3'd0;
    cyc();
    bus.Start = 1'b0;  bus.FrogHome = 1'b0;
    check("ign_homes",   bus.HomesFilled, 5'b00100);
    check("ign_load",    bus.LevelLoad, 0);
    check("ign_running", bus.Running, 0);
    frames(59);
    check("pause_running", bus.Running, 0);
    check("pause_time",    bus.TimeLeft, 1798);
    frames(1);
    check("resp_running", bus.Running, 1);
    check("resp_respawn", bus.FrogRespawn, 1);
    check("resp_homes",   bus.HomesFilled, 5'b00100);
    check("resp_time",    bus.TimeLeft, 1800);

    // Simultaneous death and home: death wins
    bus.FrogDied = 1'b1;  bus.FrogHome = 1'b1;  bus.HomeSlot = 3'd1;
    cyc();
    bus.FrogDied = 1'b0;  bus.FrogHome = 1'b0;
    check("sim_lives", bus.Lives, 1);
    check("sim_homes", bus.HomesFilled, 5'b00100);
    check("sim_score", bus.Score, 1300);
    frames(60);
    check("sim_resp_running", bus.Running, 1);

    // Out-of-range slot is a death; third death ends the game
    home(3'd5);
    check("bad_slot_lives",   bus.Lives, 0);
    check("bad_slot_running", bus.Running, 0);
    check("bad_slot_homes",   bus.HomesFilled, 5'b00100);
    frames(59);
    check("go_wait", bus.GameOver, 0);
    frames(1);
    check("go_flag",    bus.GameOver, 1);
    check("go_running", bus.Running, 0);
    cyc();
    check("go_hold", bus.GameOver, 1);

    bus.Start = 1'b1;
    cyc();
    bus.Start = 1'b0;
    check("rs_load",  bus.LevelLoad, 1);
    check("rs_level", bus.Level, 1);
    check("rs_lives", bus.Lives, 3);
    check("rs_score", bus.Score, 0);
    check("rs_over",  bus.GameOver, 0);
    check("rs_homes", bus.HomesFilled, 0);
    cyc();
    check("rs_running", bus.Running, 1);

    // Clear levels 1..3 to win
    for (int lvl = 1; lvl <= 3; lvl++) begin
      for (int s = 0; s < 5; s++) begin
        home(3'(s));
        cyc();
      end
      frames(60);
      if (lvl < 3) begin
        check("win_lvl_load",  bus.LevelLoad, 1);
        check("win_lvl_level", bus.Level, 32'(lvl + 1));
        cyc();
      end
    end
    check("won_flag",    bus.GameWon, 1);
    check("won_level",   bus.Level, 3);
    check("won_score",   bus.Score, 3750);
    check("won_running", bus.Running, 0);

    // Round timer expiry on the short-round instance
    bus_t.Start = 1'b1;
    cyc();
    bus_t.Start = 1'b0;
    cyc();
    check("t_time_start", bus_t.TimeLeft, 4);
    for (int i = 0; i < 3; i++) begin
      bus_t.frame_tick = 1'b1;
      cyc();
    end
    bus_t.frame_tick = 1'b0;
    check("t_time_1",  bus_t.TimeLeft, 1);
    check("t_running", bus_t.Running, 1);
    check("t_lives_3", bus_t.Lives, 3);
    bus_t.frame_tick = 1'b1;
    cyc();
    check("t_time_0",      bus_t.TimeLeft, 0);
    check("t_lives_2",     bus_t.Lives, 2);
    check("t_running_off", bus_t.Running, 0);
    cyc();
    bus_t.frame_tick = 1'b0;

    // Reset mid-pause
    Reset_n = 1'b0;
    cyc();
    check("t_rst_lives",   bus_t.Lives, 3);
    check("t_rst_time",    bus_t.TimeLeft, 4);
    check("t_rst_running", bus_t.Running, 0);
    check("t_rst_respawn", bus_t.FrogRespawn, 0);
    check("win_rst_flag",  bus.GameWon, 0);
    check("win_rst_score", bus.Score, 0);
    Reset_n = 1'b1;
    cyc();
    check("t_idle_load",    bus_t.LevelLoad, 0);
    check("t_idle_running", bus_t.Running, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
